transistor_sweep_seq: RTL

- Digital sequencer for the raw-transistor analog test array.
- Selects one device under test through one-hot analog switch enables and steps a gate-drive DAC code across a programmed range.
- Waits a programmable settle time at each code, samples the external comparator output, and streams (code, bit) results over a valid/ready handshake.
- Sits between the ui_in/uio_in control pins and the uo_out/uio_out pins that drive the analog switch matrix and the R-2R DAC.

---
 rtl/transistor_sweep_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/transistor_sweep_seq.sv
// Transistor sweep sequencer: one-hot device select, DAC code sweep with settle/sample and a
// valid/ready result stream. Optional macro SWEEP_AVG_EN: three samples per code, majority vote.
module transistor_sweep_seq #(
  parameter int CODE_W   = 6,
  parameter int SETTLE_W = 8,
  parameter int DEV_N    = 4,
  localparam int SEL_W   = (DEV_N > 1) ? $clog2(DEV_N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic                abort,
  input  logic [SEL_W-1:0]    dev_sel,
  input  logic [CODE_W-1:0]   code_lo,
  input  logic [CODE_W-1:0]   code_hi,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                comp_in,
  output logic [CODE_W-1:0]   dac_code,
  output logic [DEV_N-1:0]    dev_en,
  output logic                busy,
  output logic                done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CODE_W-1:0]   res_code,
  output logic                res_bit
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_r;
  logic                launch_r;
  logic [SEL_W-1:0]    dev_sel_r;
  logic [CODE_W-1:0]   code_lo_r;
  logic [CODE_W-1:0]   code_hi_r;
  logic [SETTLE_W-1:0] settle_r;
  logic [SETTLE_W-1:0] cnt_r;
  logic                comp_meta_r;
  logic                comp_sync_r;
`ifdef SWEEP_AVG_EN
  logic [1:0]          samp_idx_r;
  logic [1:0]          samp_r;
`endif

  function automatic logic [DEV_N-1:0] dev_onehot(input logic [SEL_W-1:0] sel);
    logic [DEV_N-1:0] oh;
    oh      = {DEV_N{1'b0}};
    oh[sel] = 1'b1;
    return oh;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two-flop comparator synchronizer; free-running regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_meta_r <= 1'b0;
      comp_sync_r <= 1'b0;
    end else begin
      comp_meta_r <= comp_in;
      comp_sync_r <= comp_meta_r;
    end
  end

  // Sweep FSM with registered outputs; abort overrides everything, ena=0 freezes the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      launch_r  <= 1'b0;
      dev_sel_r <= {SEL_W{1'b0}};
      code_lo_r <= {CODE_W{1'b0}};
      code_hi_r <= {CODE_W{1'b0}};
      settle_r  <= {SETTLE_W{1'b0}};
      cnt_r     <= {SETTLE_W{1'b0}};
      dac_code  <= {CODE_W{1'b0}};
      dev_en    <= {DEV_N{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_code  <= {CODE_W{1'b0}};
      res_bit   <= 1'b0;
`ifdef SWEEP_AVG_EN
      samp_idx_r <= 2'd0;
      samp_r     <= 2'd0;
`endif
    end else if (abort) begin
      state_r   <= IDLE;
      launch_r  <= 1'b0;
      dev_en    <= {DEV_N{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // Parameters are latched on the start edge and acted on one cycle later.
          if (launch_r) begin
            launch_r <= 1'b0;
            busy     <= 1'b1;
            if (code_lo_r <= code_hi_r) begin
              state_r  <= SETTLE;
              dac_code <= code_lo_r;
              dev_en   <= dev_onehot(dev_sel_r);
              cnt_r    <= settle_r;
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end else if (start) begin
            launch_r  <= 1'b1;
            dev_sel_r <= dev_sel;
            code_lo_r <= code_lo;
            code_hi_r <= code_hi;
            settle_r  <= settle;
          end else begin
            launch_r <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_r == {SETTLE_W{1'b0}}) begin
            state_r <= SAMPLE;
`ifdef SWEEP_AVG_EN
            samp_idx_r <= 2'd0;
`endif
          end else begin
            cnt_r <= cnt_r - SETTLE_W'(1);
          end
        end
        SAMPLE: begin
`ifdef SWEEP_AVG_EN
          if (samp_idx_r == 2'd2) begin
            res_bit   <= maj3(samp_r[0], samp_r[1], comp_sync_r);
            res_code  <= dac_code;
            res_valid <= 1'b1;
            state_r   <= RESULT;
          end else begin
            samp_r[samp_idx_r[0]] <= comp_sync_r;
            samp_idx_r            <= samp_idx_r + 2'd1;
          end
`else
          res_bit   <= comp_sync_r;
          res_code  <= dac_code;
          res_valid <= 1'b1;
          state_r   <= RESULT;
`endif
        end
        RESULT: begin
          // Compare before increment so code_hi = all-ones ends without wrapping.
          if (res_ready) begin
            res_valid <= 1'b0;
            if (dac_code == code_hi_r) begin
              state_r <= DONE;
              done    <= 1'b1;
              dev_en  <= {DEV_N{1'b0}};
            end else begin
              dac_code <= dac_code + CODE_W'(1);
              cnt_r    <= settle_r;
              state_r  <= SETTLE;
            end
          end else begin
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          dev_en  <= {DEV_N{1'b0}};
        end
        default: begin
          state_r   <= IDLE;
          launch_r  <= 1'b0;
          busy      <= 1'b0;
          dev_en    <= {DEV_N{1'b0}};
          res_valid <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule
